// File: rtl/wm_dct_pkg.sv
// Shared constants and width helpers for the 4x4 integer DCT used by the watermark embedder.
package wm_dct_pkg;

    localparam int CORE_PLAIN = 0;
    localparam int CORE_H264  = 1;

    // Both butterflies have an absolute gain of at most 6, so each pass needs 3 extra bits.
    function automatic int w1_of(input int width);
        return width + 4;
    endfunction

    function automatic int w2_of(input int width);
        return width + 7;
    endfunction

endpackage

// File: rtl/dct4x4_2d_stream_if.sv
// Row-in / coefficient-column-out stream bundle for dct4x4_2d_stream.
interface dct4x4_2d_stream_if #(
    parameter int WIDTH = 8
);
    import wm_dct_pkg::*;

    localparam int W2 = w2_of(WIDTH);

    logic                 in_valid;
    logic                 in_ready;
    logic [4*WIDTH-1:0]   in_row;
    logic                 out_valid;
    logic                 out_ready;
    logic [4*W2-1:0]      out_col;
    logic [1:0]           out_idx;
    logic                 out_last;

    modport slave (
        input  in_valid, in_row, out_ready,
        output in_ready, out_valid, out_col, out_idx, out_last
    );

    modport master (
        output in_valid, in_row, out_ready,
        input  in_ready, out_valid, out_col, out_idx, out_last
    );

endinterface

// File: rtl/dct4x4_2d_stream_dct4_1d.sv
// Combinational 4-point integer DCT butterfly; lanes are signed, lane 0 at the LSBs.
module dct4_1d
    import wm_dct_pkg::*;
#(
    parameter int IN_W      = 9,
    parameter int OUT_W     = 12,
    parameter int CORE_MODE = CORE_PLAIN
) (
    input  logic [4*IN_W-1:0]  din,
    output logic [4*OUT_W-1:0] dout
);

    logic signed [OUT_W-1:0] a [4];
    logic signed [OUT_W-1:0] s03, s12, d03, d12;
    logic signed [OUT_W-1:0] b0, b1, b2, b3;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ext
            assign a[gi] = {{(OUT_W-IN_W){din[gi*IN_W+IN_W-1]}}, din[gi*IN_W +: IN_W]};
        end
    endgenerate

    assign s03 = a[0] + a[3];
    assign s12 = a[1] + a[2];
    assign d03 = a[0] - a[3];
    assign d12 = a[1] - a[2];

    assign b0 = s03 + s12;
    assign b2 = s03 - s12;

    generate
        if (CORE_MODE == CORE_H264) begin : g_h264
            assign b1 = (d03 <<< 1) + d12;
            assign b3 = d03 - (d12 <<< 1);
        end else begin : g_plain
            // a2 - a1 is just the negated d12 term
            assign b1 = d03;
            assign b3 = -d12;
        end
    endgenerate

    assign dout = {b3, b2, b1, b0};

endmodule

// File: rtl/dct4x4_2d_stream.sv
// Streaming 2-D 4x4 DCT: row transform into a ping-pong transpose buffer, column transform on read.
module dct4x4_2d_stream
    import wm_dct_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CORE_MODE = CORE_PLAIN
) (
    input  logic               clk,
    input  logic               rst,
    dct4x4_2d_stream_if.slave  bus
);

    localparam int XW = WIDTH + 1;
    localparam int W1 = w1_of(WIDTH);
    localparam int W2 = w2_of(WIDTH);

    logic [4*XW-1:0] row_ext;
    logic [4*W1-1:0] row_res;
    logic [4*W1-1:0] col_in;
    logic [4*W2-1:0] col_res;

    logic [W1-1:0]   bank_reg [2][4][4];
    logic [1:0]      full_reg, full_next;
    logic            wr_bank_reg, wr_bank_next;
    logic [1:0]      wr_row_reg, wr_row_next;
    logic            rd_bank_reg, rd_bank_next;
    logic [1:0]      rd_col_reg, rd_col_next;

    logic            out_valid_reg;
    logic [4*W2-1:0] out_col_reg;
    logic [1:0]      out_idx_reg;
    logic            out_last_reg;

    logic            wr_fire;
    logic            rd_fire;

    // 8-bit inputs are pixels (unsigned); any other width is two's complement.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_row_ext
            if (WIDTH == 8) begin : g_unsigned
                assign row_ext[gi*XW +: XW] = {1'b0, bus.in_row[gi*WIDTH +: WIDTH]};
            end else begin : g_signed
                assign row_ext[gi*XW +: XW] = {bus.in_row[gi*WIDTH+WIDTH-1],
                                               bus.in_row[gi*WIDTH +: WIDTH]};
            end
        end
    endgenerate

    dct4_1d #(
        .IN_W      (XW),
        .OUT_W     (W1),
        .CORE_MODE (CORE_MODE)
    ) u_row (
        .din  (row_ext),
        .dout (row_res)
    );

    // Column c of the read bank is the transpose read: element c of every stored row.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col_sel
            assign col_in[gi*W1 +: W1] = bank_reg[rd_bank_reg][gi][rd_col_reg];
        end
    endgenerate

    dct4_1d #(
        .IN_W      (W1),
        .OUT_W     (W2),
        .CORE_MODE (CORE_MODE)
    ) u_col (
        .din  (col_in),
        .dout (col_res)
    );

    assign bus.in_ready  = ~full_reg[wr_bank_reg];
    assign wr_fire       = bus.in_valid & ~full_reg[wr_bank_reg];
    assign rd_fire       = full_reg[rd_bank_reg] & (~out_valid_reg | bus.out_ready);

    assign bus.out_valid = out_valid_reg;
    assign bus.out_col   = out_col_reg;
    assign bus.out_idx   = out_idx_reg;
    assign bus.out_last  = out_last_reg;

    // A bank is only written while empty and only read while full, so the two sides never collide.
    always_comb begin
        full_next    = full_reg;
        wr_bank_next = wr_bank_reg;
        wr_row_next  = wr_row_reg;
        rd_bank_next = rd_bank_reg;
        rd_col_next  = rd_col_reg;
        if (wr_fire) begin
            wr_row_next = wr_row_reg + 2'd1;
            if (wr_row_reg == 2'd3) begin
                full_next[wr_bank_reg] = 1'b1;
                wr_bank_next           = ~wr_bank_reg;
            end
        end
        if (rd_fire) begin
            rd_col_next = rd_col_reg + 2'd1;
            if (rd_col_reg == 2'd3) begin
                full_next[rd_bank_reg] = 1'b0;
                rd_bank_next           = ~rd_bank_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_reg    <= 2'b00;
            wr_bank_reg <= 1'b0;
            wr_row_reg  <= 2'd0;
            rd_bank_reg <= 1'b0;
            rd_col_reg  <= 2'd0;
        end else begin
            full_reg    <= full_next;
            wr_bank_reg <= wr_bank_next;
            wr_row_reg  <= wr_row_next;
            rd_bank_reg <= rd_bank_next;
            rd_col_reg  <= rd_col_next;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int k = 0; k < 4; k++) begin
                bank_reg[wr_bank_reg][wr_row_reg][k] <= row_res[k*W1 +: W1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_col_reg   <= '0;
            out_idx_reg   <= 2'd0;
            out_last_reg  <= 1'b0;
        end else if (rd_fire) begin
            out_valid_reg <= 1'b1;
            out_col_reg   <= col_res;
            out_idx_reg   <= rd_col_reg;
            out_last_reg  <= (rd_col_reg == 2'd3);
        end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dct4x4_2d_stream.sv
// Directed bench for dct4x4_2d_stream: three instances (8-bit plain, 8-bit H.264, 12-bit signed H.264).
module tb_dct4x4_2d_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sel = 2'd0;
    logic       drv_valid = 1'b0;
    logic       drv_ready = 1'b0;
    logic [11:0] pxv [4];

    int checks = 0;
    int errors = 0;

    int blk   [4][4];
    int exp_y [8][4];

    logic obs_in_ready, obs_valid, obs_last;
    logic [1:0] obs_idx;
    int obs_y [4];

    always #5 clk = ~clk;

    dct4x4_2d_stream_if #(.WIDTH(8))  if0 ();
    dct4x4_2d_stream_if #(.WIDTH(8))  if1 ();
    dct4x4_2d_stream_if #(.WIDTH(12)) if2 ();

    dct4x4_2d_stream #(.WIDTH(8),  .CORE_MODE(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    dct4x4_2d_stream #(.WIDTH(8),  .CORE_MODE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    dct4x4_2d_stream #(.WIDTH(12), .CORE_MODE(1)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    assign if0.in_valid  = drv_valid && (sel == 2'd0);
    assign if1.in_valid  = drv_valid && (sel == 2'd1);
    assign if2.in_valid  = drv_valid && (sel == 2'd2);
    assign if0.out_ready = drv_ready && (sel == 2'd0);
    assign if1.out_ready = drv_ready && (sel == 2'd1);
    assign if2.out_ready = drv_ready && (sel == 2'd2);
    assign if0.in_row = {pxv[3][7:0], pxv[2][7:0], pxv[1][7:0], pxv[0][7:0]};
    assign if1.in_row = {pxv[3][7:0], pxv[2][7:0], pxv[1][7:0], pxv[0][7:0]};
    assign if2.in_row = {pxv[3], pxv[2], pxv[1], pxv[0]};

    always_comb begin
        obs_in_ready = if0.in_ready;
        obs_valid    = if0.out_valid;
        obs_idx      = if0.out_idx;
        obs_last     = if0.out_last;
        for (int k = 0; k < 4; k++) obs_y[k] = $signed(if0.out_col[k*15 +: 15]);
        if (sel == 2'd1) begin
            obs_in_ready = if1.in_ready;
            obs_valid    = if1.out_valid;
            obs_idx      = if1.out_idx;
            obs_last     = if1.out_last;
            for (int k = 0; k < 4; k++) obs_y[k] = $signed(if1.out_col[k*15 +: 15]);
        end else if (sel == 2'd2) begin
            obs_in_ready = if2.in_ready;
            obs_valid    = if2.out_valid;
            obs_idx      = if2.out_idx;
            obs_last     = if2.out_last;
            for (int k = 0; k < 4; k++) obs_y[k] = $signed(if2.out_col[k*19 +: 19]);
        end
    end

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        drv_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Presents one row at a negedge and returns at the negedge right after it is accepted.
    task automatic send_row(input int p0, input int p1, input int p2, input int p3);
        int w = 0;
        pxv[0] = 12'(p0); pxv[1] = 12'(p1); pxv[2] = 12'(p2); pxv[3] = 12'(p3);
        drv_valid = 1'b1;
        while (obs_in_ready !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (obs_in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL row_accept_timeout: in_ready=%b required 1", obs_in_ready);
        end
        $display("row in: %0d %0d %0d %0d", p0, p1, p2, p3);
        @(negedge clk);
    endtask

    task automatic send_block();
        for (int r = 0; r < 4; r++) send_row(blk[r][0], blk[r][1], blk[r][2], blk[r][3]);
    endtask

    task automatic collect(input int n);
        for (int b = 0; b < n; b++) begin
            int w = 0;
            while (obs_valid !== 1'b1 && w < 40) begin
                @(negedge clk);
                w++;
            end
            checks++;
            if (obs_valid !== 1'b1) begin
                errors++;
                $display("FAIL collect_timeout beat %0d: out_valid=%b required 1", b, obs_valid);
                return;
            end
            $display("col out: beat %0d idx=%0d last=%b y=%0d %0d %0d %0d",
                     b, obs_idx, obs_last, obs_y[0], obs_y[1], obs_y[2], obs_y[3]);
            checks++;
            if (obs_idx !== 2'(b % 4)) begin
                errors++;
                $display("FAIL collect_idx beat %0d: got %0d required %0d", b, obs_idx, b % 4);
            end
            checks++;
            if (obs_last !== (b % 4 == 3)) begin
                errors++;
                $display("FAIL collect_last beat %0d: got %b required %b", b, obs_last, (b % 4 == 3));
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (obs_y[k] !== exp_y[b][k]) begin
                    errors++;
                    $display("FAIL collect_y beat %0d Y[%0d]: got %0d required %0d", b, k, obs_y[k], exp_y[b][k]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        sel = 2'd0;
        rst = 1'b1;
        drv_valid = 1'b0;
        drv_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (obs_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", obs_in_ready); end
        checks++;
        if (obs_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", obs_valid); end
        checks++;
        if (obs_idx !== 2'd0) begin errors++; $display("FAIL reset_out_idx: got %0d required 0", obs_idx); end
        checks++;
        if (obs_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b required 0", obs_last); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs_y[k] !== 0) begin errors++; $display("FAIL reset_out_col Y[%0d]: got %0d required 0", k, obs_y[k]); end
        end
        rst = 1'b0;
        $display("reset checked");
    endtask

    task automatic test_dc_latency();
        sel = 2'd0;
        pulse_reset();
        drv_ready = 1'b1;
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) blk[r][c] = 128;
        send_block();
        drv_valid = 1'b0;
        checks++;
        if (obs_valid !== 1'b0) begin errors++; $display("FAIL dc_latency_early: out_valid=%b required 0", obs_valid); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            $display("col out: dc idx=%0d last=%b y=%0d %0d %0d %0d", obs_idx, obs_last, obs_y[0], obs_y[1], obs_y[2], obs_y[3]);
            checks++;
            if (obs_valid !== 1'b1) begin errors++; $display("FAIL dc_valid col %0d: got %b required 1", c, obs_valid); end
            checks++;
            if (obs_idx !== 2'(c)) begin errors++; $display("FAIL dc_idx col %0d: got %0d required %0d", c, obs_idx, c); end
            checks++;
            if (obs_last !== (c == 3)) begin errors++; $display("FAIL dc_last col %0d: got %b required %b", c, obs_last, (c == 3)); end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (obs_y[k] !== ((c == 0 && k == 0) ? 2048 : 0)) begin
                    errors++;
                    $display("FAIL dc_y col %0d Y[%0d]: got %0d required %0d", c, k, obs_y[k], (c == 0 && k == 0) ? 2048 : 0);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (obs_valid !== 1'b0) begin errors++; $display("FAIL dc_drain: out_valid=%b required 0", obs_valid); end
    endtask

    task automatic test_impulse_plain();
        sel = 2'd0;
        pulse_reset();
        drv_ready = 1'b1;
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) blk[r][c] = 0;
        blk[0][0] = 255;
        for (int c = 0; c < 4; c++) for (int k = 0; k < 4; k++) exp_y[c][k] = (k < 3 && c < 3) ? 255 : 0;
        send_block();
        drv_valid = 1'b0;
        collect(4);
    endtask

    task automatic test_impulse_h264();
        int s [4] = '{1, 2, 1, 1};
        sel = 2'd1;
        pulse_reset();
        drv_ready = 1'b1;
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) blk[r][c] = 0;
        blk[0][0] = 255;
        for (int c = 0; c < 4; c++) for (int k = 0; k < 4; k++) exp_y[c][k] = 255 * s[k] * s[c];
        send_block();
        drv_valid = 1'b0;
        collect(4);
    endtask

    task automatic test_signed();
        sel = 2'd2;
        pulse_reset();
        drv_ready = 1'b1;
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) blk[r][c] = -2048;
        for (int c = 0; c < 4; c++) for (int k = 0; k < 4; k++) exp_y[c][k] = (c == 0 && k == 0) ? -32768 : 0;
        send_block();
        drv_valid = 1'b0;
        collect(4);
    endtask

    task automatic test_back_pressure();
        sel = 2'd0;
        pulse_reset();
        drv_ready = 1'b0;
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) blk[r][c] = 0;
        blk[0][0] = 255;
        send_block();
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) blk[r][c] = 128;
        send_block();
        drv_valid = 1'b0;
        checks++;
        if (obs_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full: got %b required 0", obs_in_ready); end
        for (int pass = 0; pass < 2; pass++) begin
            checks++;
            if (obs_valid !== 1'b1 || obs_idx !== 2'd0 || obs_last !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_ctrl pass %0d: valid=%b idx=%0d last=%b required 1 0 0", pass, obs_valid, obs_idx, obs_last);
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (obs_y[k] !== ((k < 3) ? 255 : 0)) begin
                    errors++;
                    $display("FAIL bp_hold_y pass %0d Y[%0d]: got %0d required %0d", pass, k, obs_y[k], (k < 3) ? 255 : 0);
                end
            end
            repeat (5) @(negedge clk);
        end
        checks++;
        if (obs_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_stall: got %b required 0", obs_in_ready); end
        for (int c = 0; c < 4; c++) for (int k = 0; k < 4; k++) begin
            exp_y[c][k]     = (k < 3 && c < 3) ? 255 : 0;
            exp_y[c + 4][k] = (c == 0 && k == 0) ? 2048 : 0;
        end
        drv_ready = 1'b1;
        collect(8);
        checks++;
        if (obs_in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_release: got %b required 1", obs_in_ready); end
    endtask

    task automatic test_reset_mid_block();
        int spurious = 0;
        sel = 2'd0;
        pulse_reset();
        drv_ready = 1'b1;
        send_row(200, 10, 77, 3);
        send_row(5, 250, 9, 100);
        drv_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 4; r++) begin
            blk[r][0] = 10; blk[r][1] = 20; blk[r][2] = 30; blk[r][3] = 40;
        end
        for (int c = 0; c < 4; c++) for (int k = 0; k < 4; k++) exp_y[c][k] = 0;
        exp_y[0][0] = 400;
        exp_y[1][0] = -120;
        exp_y[3][0] = 40;
        send_block();
        drv_valid = 1'b0;
        collect(4);
        repeat (8) begin
            if (obs_valid === 1'b1) spurious++;
            @(negedge clk);
        end
        checks++;
        if (spurious != 0) begin errors++; $display("FAIL mid_reset_extra_beats: got %0d required 0", spurious); end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) pxv[k] = 12'd0;
        test_reset();
        test_dc_latency();
        test_impulse_plain();
        test_impulse_h264();
        test_signed();
        test_back_pressure();
        test_reset_mid_block();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
